// File: rtl/sa_ws_sequencer.sv
// sa_ws_sequencer: weight-load / skewed-compute sequencer for a weight-stationary systolic array
module sa_ws_sequencer #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_vec,
    input  logic                    skip_wload,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
    output logic                    pe_en,
    output logic                    pe_w_en,
    output logic                    wt_rd_en,
    output logic [$clog2(ROWS)-1:0] wt_row_idx,
    output logic                    act_rd_en,
    output logic [CNT_W-1:0]        act_vec_idx,
    output logic [ROWS-1:0]         act_lane_en,
    output logic [COLS-1:0]         out_valid
);
    localparam int TW = CNT_W + 1;
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d, last_t, nv_x;
    logic [CNT_W-1:0]  nv_q, nv_d;
    logic              stall, comp_go;
    logic              busy_d, done_d, pe_en_d, load_d, act_rd_en_d;
    logic [RW-1:0]     wt_row_idx_d;
    logic [CNT_W-1:0]  act_vec_idx_d;
    logic [ROWS-1:0]   act_lane_en_d;
    logic [COLS-1:0]   out_valid_d;

    // cnt_q is the step shown this cycle; a stall re-shows it as a bubble and resumes with the next step
    assign last_t = {1'b0, nv_q} + TW'(ROWS + COLS - 2);
    assign stall  = hold && (state_q == LOAD || state_q == COMP);
    assign nv_x   = {1'b0, nv_d};

    // next job position
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nv_d    = nv_q;
        case (state_q)
            IDLE: if (start && num_vec != '0) begin
                state_d = skip_wload ? COMP : LOAD;
                cnt_d   = '0;
                nv_d    = num_vec;
            end
            LOAD: if (!hold) begin
                state_d = (cnt_q == TW'(ROWS - 1)) ? COMP : LOAD;
                cnt_d   = (cnt_q == TW'(ROWS - 1)) ? '0 : cnt_q + TW'(1);
            end
            COMP: if (!hold) begin
                state_d = (cnt_q == last_t) ? DONE : COMP;
                cnt_d   = cnt_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // strobes and indices for the step being entered, so every output comes straight from a flop
    always_comb begin
        busy_d        = state_d == LOAD || state_d == COMP;
        done_d        = state_d == DONE;
        pe_en_d       = busy_d && !stall;
        load_d        = state_d == LOAD && !stall;
        comp_go       = state_d == COMP && !stall;
        act_rd_en_d   = comp_go && cnt_d < nv_x;
        wt_row_idx_d  = state_d == LOAD ? RW'(ROWS - 1) - cnt_d[RW-1:0] : (state_d == COMP ? wt_row_idx : '0);
        act_vec_idx_d = state_d == COMP ? (cnt_d < nv_x ? cnt_d[CNT_W-1:0] : act_vec_idx) : '0;
        for (int r = 0; r < ROWS; r++)
            act_lane_en_d[r] = comp_go && cnt_d >= TW'(r) && cnt_d - TW'(r) < nv_x;
        for (int c = 0; c < COLS; c++)
            out_valid_d[c] = comp_go && cnt_d >= TW'(ROWS + c) && cnt_d - TW'(ROWS + c) < nv_x;
    end

    // state, counters and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            nv_q        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pe_en       <= 1'b0;
            pe_w_en     <= 1'b0;
            wt_rd_en    <= 1'b0;
            wt_row_idx  <= '0;
            act_rd_en   <= 1'b0;
            act_vec_idx <= '0;
            act_lane_en <= '0;
            out_valid   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nv_q        <= nv_d;
            busy        <= busy_d;
            done        <= done_d;
            pe_en       <= pe_en_d;
            pe_w_en     <= load_d;
            wt_rd_en    <= load_d;
            wt_row_idx  <= wt_row_idx_d;
            act_rd_en   <= act_rd_en_d;
            act_vec_idx <= act_vec_idx_d;
            act_lane_en <= act_lane_en_d;
            out_valid   <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_sa_ws_sequencer.sv
// tb_sa_ws_sequencer: directed and random checks of sa_ws_sequencer against a step-list model
module tb_sa_ws_sequencer;
    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 16;

    typedef struct packed {
        logic        busy, done, pe_en, pe_w_en, wt_rd_en;
        logic [1:0]  wt_row;
        logic        act_rd;
        logic [15:0] act_idx;
        logic [3:0]  lane, ov;
    } exp_t;

    logic CLK = 0, RESET = 0, start = 0, skip_wload = 0, hold = 0;
    logic [W-1:0] num_vec = '0;
    logic busy, done, pe_en, pe_w_en, wt_rd_en, act_rd_en;
    logic [1:0] wt_row_idx;
    logic [W-1:0] act_vec_idx;
    logic [R-1:0] act_lane_en;
    logic [C-1:0] out_valid;

    int   cmps = 0, errs = 0, cyc_n = 0, k;
    exp_t cur, q[$];

    sa_ws_sequencer #(.ROWS(R), .COLS(C), .CNT_W(W)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .num_vec(num_vec), .skip_wload(skip_wload),
        .hold(hold), .busy(busy), .done(done), .pe_en(pe_en), .pe_w_en(pe_w_en),
        .wt_rd_en(wt_rd_en), .wt_row_idx(wt_row_idx), .act_rd_en(act_rd_en),
        .act_vec_idx(act_vec_idx), .act_lane_en(act_lane_en), .out_valid(out_valid)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t st_load(int i);
        exp_t e = '0;
        e.busy = 1; e.pe_en = 1; e.pe_w_en = 1; e.wt_rd_en = 1;
        e.wt_row = 2'(R - 1 - i);
        return e;
    endfunction

    function automatic exp_t st_comp(int t, int n);
        exp_t e = '0;
        e.busy = 1; e.pe_en = 1;
        e.act_rd = t < n;
        e.act_idx = 16'(t < n ? t : n - 1);
        for (int r = 0; r < R; r++) e.lane[r] = t >= r && t < r + n;
        for (int c = 0; c < C; c++) e.ov[c] = t >= R + c && t < R + c + n;
        return e;
    endfunction

    task automatic check(input string tag);
        logic [31:0] obs;
        obs = {busy, done, pe_en, pe_w_en, wt_rd_en, wt_row_idx, act_rd_en, act_vec_idx, act_lane_en, out_valid};
        cmps++;
        assert (obs === cur) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, cur);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        cmps++;
        assert (got === want) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic cyc(input logic s, input int n, input logic sk, input logic h);
        exp_t nx, dn;
        start = s; num_vec = W'(n); skip_wload = sk; hold = h;
        if (cur.busy && h) begin
            nx = cur;
            nx.pe_en = 0; nx.pe_w_en = 0; nx.wt_rd_en = 0; nx.act_rd = 0; nx.lane = '0; nx.ov = '0;
        end else if (q.size() != 0) begin
            nx = q.pop_front();
        end else if (!cur.done && s && n != 0) begin
            if (!sk) for (int i = 0; i < R; i++) q.push_back(st_load(i));
            for (int t = 0; t < n + R + C - 1; t++) q.push_back(st_comp(t, n));
            dn = '0; dn.done = 1;
            q.push_back(dn);
            nx = q.pop_front();
        end else begin
            nx = '0;
        end
        @(posedge CLK); #1;
        cur = nx;
        cyc_n++;
        check($sformatf("cyc%0d", cyc_n));
    endtask

    task automatic job_len(input int n, input logic sk, input int hold_k, output int kk);
        cyc(1, n, sk, 0);
        kk = 1;
        while (done !== 1'b1 && kk < 100) begin
            cyc(0, 0, 0, kk == hold_k || kk == hold_k + 1);
            kk++;
        end
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        cur = '0;
        #3 check("reset_state");
        @(posedge CLK); #2 RESET = 1;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        job_len(3, 0, -1, k);  check_int("done_cycle_load", k, 15);
        job_len(3, 1, -1, k);  check_int("done_cycle_skip", k, 11);
        job_len(3, 0, 10, k);  check_int("done_cycle_hold2", k, 17);
        job_len(1, 0, -1, k);  check_int("done_cycle_nv1", k, 13);
        cyc(1, 2, 0, 0);
        for (int i = 0; i < 16; i++) cyc(1, 5, 1, 0);
        cyc(1, 3, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
        #2 RESET = 0;
        #1 cur = '0; q.delete();
        check("async_reset");
        @(posedge CLK); #1 check("reset_held");
        #1 RESET = 1;
        job_len(3, 0, -1, k);  check_int("done_after_reset", k, 15);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/sa_ws_sequencer.md
# sa_ws_sequencer

Sequencer for a ROWS x COLS weight-stationary systolic array of single-weight MAC PEs. It runs a weight-load phase that shifts one weight row per cycle down the columns, then a compute phase with row-skewed activation lane enables. It generates per-column result-valid strobes and signals completion. The block sits between the layer-level control and the PE array and its weight and activation buffers.

## Interface
- ROWS, 8, array rows (activation lanes, weight rows); >= 2
- COLS, 8, array columns (output lanes); >= 2
- CNT_W, 16, width of the vector count
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- start  in  1  launch request; sampled only in IDLE
- num_vec  in  CNT_W  activation vectors to stream; sampled with start
- skip_wload  in  1  reuse resident weights, skip LOAD; sampled with start
- hold  in  1  stall: freezes sequencer and array
- busy  out  1  high in LOAD and COMP
- done  out  1  one-cycle pulse on job completion
- pe_en  out  1  array EN
- pe_w_en  out  1  array W_EN
- wt_rd_en  out  1  weight buffer read strobe
- wt_row_idx  out  $clog2(ROWS)  weight row to present at array top
- act_rd_en  out  1  activation buffer read strobe
- act_vec_idx  out  CNT_W  vector index read this cycle
- act_lane_en  out  ROWS  per-row activation gate; a gated-off lane drives 0
- out_valid  out  COLS  bottom-row out_sum of column c holds a finished result

## Operation
- FSM states: IDLE, LOAD, COMP, DONE. All outputs are registered.
- IDLE -> LOAD on start with num_vec != 0 and skip_wload = 0.
- IDLE -> COMP on start with num_vec != 0 and skip_wload = 1.
- start with num_vec = 0 is ignored. start outside IDLE is ignored.
- LOAD:
  - Lasts ROWS cycles, step i = 0..ROWS-1.
  - pe_en = pe_w_en = wt_rd_en = 1.
  - wt_row_idx = ROWS-1-i, so the last row enters first and row 0 lands in array row 0.
  - Weight data must be valid at the array top in the same cycle.
  - Next state: COMP.
- COMP:
  - Counter t runs 0..L-1, where L = num_vec + ROWS + COLS - 1. pe_en = 1, pe_w_en = 0.
  - act_rd_en = (t < num_vec); act_vec_idx = t while t < num_vec, otherwise it holds its last value.
  - act_lane_en[r] = (r <= t < r + num_vec). Lane r carries element r of vector t-r.
  - out_valid[c] = (ROWS + c <= t < ROWS + c + num_vec). The result for vector v appears at t = v + ROWS + c.
  - After t = L-1, next state is DONE.
- DONE: lasts one cycle. done = 1, all other outputs 0, then IDLE.
- hold = 1 in LOAD or COMP:
  - pe_en, pe_w_en, wt_rd_en, act_rd_en, act_lane_en and out_valid are forced to 0.
  - Counters, state and index outputs freeze. busy stays 1.
  - The job resumes on the first cycle after hold drops, with the same strobe values it would have had.
- hold in IDLE or DONE: no effect.
- Counter widths:
  - t is CNT_W+1 bits wide; L cannot overflow.
  - num_vec is at most 2^CNT_W - 1.
- Reset:
  - Asserting RESET at any time, including mid-job, forces IDLE and drives every output to 0 (act_vec_idx and wt_row_idx = 0).
  - Array weights are not preserved. A skip_wload job issued after reset computes with zero weights, and the sequencer does not check this.

## Timing
- Start edge = cycle 0 (start sampled). The first LOAD cycle is cycle 1.
- With LOAD:
  - LOAD covers cycles 1..ROWS.
  - COMP covers cycles ROWS+1..ROWS+L.
  - DONE is cycle ROWS+L+1; IDLE follows.
- With skip_wload: COMP starts at cycle 1 and every later cycle shifts down by ROWS.
- Each stall cycle extends the job by exactly one cycle.
- A start presented in the DONE cycle is ignored. The earliest accepted restart is the cycle after DONE.
- busy falls in the DONE cycle.

## Test plan
- ROWS = COLS = 4, start, num_vec = 3:
  - pe_w_en in cycles 1-4, with wt_row_idx 3, 2, 1, 0.
  - COMP in cycles 5-14 (L = 10). act_lane_en[3] in cycles 8-10.
  - out_valid[0] in cycles 9-11; out_valid[3] in cycles 12-14.
  - done in cycle 15.
- Same job with skip_wload = 1: pe_w_en never rises, COMP in cycles 1-10, done in cycle 11. With preloaded identity weights, column c outputs equal activation element c.
- hold = 1 for 2 cycles starting at COMP t = 5: pe_en and out_valid are 0 for those cycles, t stays 5, and done is delayed by exactly 2 cycles.
- start with num_vec = 0, and start while busy: no state change, no extra done, and the in-flight job's timing is unchanged.
- RESET low at COMP t = 3: all outputs 0 immediately (asynchronously). After release, state is IDLE and a new start runs the full num_vec = 3 sequence from the start.
- num_vec = 1, ROWS = COLS = 2: L = 4, and each out_valid[c] is a single one-cycle pulse at t = 2 + c.
